fifo_rd_ctrl: RTL and testbench

Read-side controller for the asynchronous FIFO. It runs entirely in the read clock domain and consumes the write pointer after the 2-flop synchronizer. It owns the read pointer in binary and Gray form, sequences the synchronous-read dual-port memory, and presents a first-word-fall-through valid/ready stream to the consumer. A 2-entry output buffer sustains one word per cycle despite the memory's 1-cycle read latency.

---
 rtl/fifo_rd_ctrl.sv | 133 +++++++++++++
 tb/tb_fifo_rd_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: read pointers, memory read sequencing and a 2-entry FWFT output buffer.
// Optional pointer-integrity checker enabled by defining FIFO_RD_PTRCHK_EN.
module fifo_rd_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH:0]   wptr_gray_sync,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  err
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0]   rptr_bin_q, rptr_bin_d;
  logic [ADDR_WIDTH:0]   rptr_gray_q, rptr_gray_d;
  logic [1:0]            buf_cnt_q, buf_cnt_d;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;

  logic [ADDR_WIDTH:0]   wptr_bin;
  logic                  mem_empty;
  logic                  pop;
  logic [1:0]            cnt_after_pop;
  logic [2:0]            occ_after;

  always_comb begin
    wptr_bin = '0;
    for (int i = 0; i <= ADDR_WIDTH; i++) begin
      wptr_bin[i] = ^(wptr_gray_sync >> i);
    end
  end

  assign mem_empty = (rptr_gray_q == wptr_gray_sync);
  assign rd_level  = wptr_bin - rptr_bin_q;

  assign rd_valid  = (buf_cnt_q != 2'd0);
  assign empty     = !rd_valid;
  assign rd_data   = head_q;
  assign rptr_gray = rptr_gray_q;
  assign mem_raddr = rptr_bin_q[ADDR_WIDTH-1:0];

  assign pop           = rd_valid && rd_ready;
  assign cnt_after_pop = buf_cnt_q - {1'b0, pop};
  // Occupancy once this cycle's pop and the in-flight arrival settle; a new read may only
  // be issued if its word will still find a free slot.
  assign occ_after     = {1'b0, cnt_after_pop} + {2'b00, inflight_q};
  assign mem_ren       = rst_n && !mem_empty && (occ_after <= 3'd1);

  always_comb begin
    rptr_bin_d  = rptr_bin_q;
    rptr_gray_d = rptr_gray_q;
    head_d      = head_q;
    skid_d      = skid_q;
    buf_cnt_d   = occ_after[1:0];
    if (mem_ren) begin
      rptr_bin_d  = rptr_bin_q + PTR_ONE;
      rptr_gray_d = rptr_bin_d ^ (rptr_bin_d >> 1);
    end
    if (pop) begin
      head_d = skid_q;
    end
    if (inflight_q) begin
      if (cnt_after_pop == 2'd0) begin
        head_d = mem_rdata;
      end else begin
        skid_d = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_bin_q  <= '0;
      rptr_gray_q <= '0;
      buf_cnt_q   <= 2'd0;
      inflight_q  <= 1'b0;
      head_q      <= '0;
      skid_q      <= '0;
    end else begin
      rptr_bin_q  <= rptr_bin_d;
      rptr_gray_q <= rptr_gray_d;
      buf_cnt_q   <= buf_cnt_d;
      inflight_q  <= mem_ren;
      head_q      <= head_d;
      skid_q      <= skid_d;
    end
  end

`ifdef FIFO_RD_PTRCHK_EN
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH:0] wptr_prev_q;
  logic [ADDR_WIDTH:0] wptr_diff;
  logic                prev_vld_q;
  logic                hop_bad;
  logic                level_bad;
  logic                err_q, err_d;

  // A legal synchronized Gray pointer moves by at most one bit per cycle; the first
  // cycle after reset has no valid predecessor to compare against.
  assign wptr_diff = wptr_gray_sync ^ wptr_prev_q;
  assign hop_bad   = prev_vld_q && ((wptr_diff & (wptr_diff - PTR_ONE)) != '0);
  assign level_bad = (rd_level > DEPTH);
  assign err_d     = err_q || hop_bad || level_bad;
  assign err       = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_prev_q <= '0;
      prev_vld_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wptr_prev_q <= wptr_gray_sync;
      prev_vld_q  <= 1'b1;
      err_q       <= err_d;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: reset, single word, stream, backpressure, wrap, error and mid-run reset.
module tb_fifo_rd_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;
`ifdef FIFO_RD_PTRCHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW:0]   wptr_gray_sync;
  logic [AW:0]   rptr_gray;
  logic          mem_ren;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata = '0;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic [AW:0]   rd_level;
  logic          err;

  logic [DW-1:0] mem [16];
  logic [DW-1:0] exp_q [$];
  int total = 0;
  int bad = 0;

  fifo_rd_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wptr_gray_sync (wptr_gray_sync),
    .rptr_gray      (rptr_gray),
    .mem_ren        (mem_ren),
    .mem_raddr      (mem_raddr),
    .mem_rdata      (mem_rdata),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .rd_data        (rd_data),
    .empty          (empty),
    .rd_level       (rd_level),
    .err            (err)
  );

  // clock / memory model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= mem[mem_raddr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  // checking / driver tasks
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [AW:0] gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic watch(input string tag);
    if (rd_valid && rd_ready) begin
      if (exp_q.size() == 0) check({tag, "_unexpected"}, 32'(exp_q.size()), 32'd1);
      else check(tag, 32'(rd_data), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rd_ready = 1'b0;
    wptr_gray_sync = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int ren_cnt;
    for (int i = 0; i < 16; i++) mem[i] = 8'hA5 + 8'(i * 59);

    // reset held with a non-empty write pointer
    rst_n = 1'b0;
    rd_ready = 1'b0;
    wptr_gray_sync = 5'h03;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_rptr", 32'(rptr_gray), 32'd0);
    check("rst_ren", 32'(mem_ren), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_data", 32'(rd_data), 32'd0);
    check("rst_raddr", 32'(mem_raddr), 32'd0);
    check("rst_level", 32'(rd_level), 32'd2);

    // single word
    do_reset();
    cyc();
    wptr_gray_sync = 5'h01;
    #1;
    check("one_ren", 32'(mem_ren), 32'd1);
    check("one_raddr", 32'(mem_raddr), 32'd0);
    check("one_level", 32'(rd_level), 32'd1);
    cyc(); #1;
    check("one_rptr", 32'(rptr_gray), 32'd1);
    check("one_ren_off", 32'(mem_ren), 32'd0);
    check("one_valid_c1", 32'(rd_valid), 32'd0);
    cyc(); #1;
    check("one_valid_c2", 32'(rd_valid), 32'd1);
    check("one_data", 32'(rd_data), 32'hA5);
    check("one_empty", 32'(empty), 32'd0);
    rd_ready = 1'b1;
    cyc(); #1;
    check("one_drained", 32'(rd_valid), 32'd0);

    // stream of 8 words at full rate
    do_reset();
    cyc();
    wptr_gray_sync = gray(5'd8);
    rd_ready = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) cyc();
      #1;
      check($sformatf("st_ren_c%0d", c), 32'(mem_ren), 32'(c < 8));
      if (c < 8) check($sformatf("st_raddr_c%0d", c), 32'(mem_raddr), 32'(c));
      check($sformatf("st_valid_c%0d", c), 32'(rd_valid), 32'(c >= 2 && c <= 9));
      if (c >= 2 && c <= 9) check($sformatf("st_data_c%0d", c), 32'(rd_data), 32'(mem[c-2]));
    end
    check("st_level", 32'(rd_level), 32'd0);

    // backpressure then drain
    do_reset();
    cyc();
    wptr_gray_sync = gray(5'd8);
    ren_cnt = 0;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) cyc();
      #1;
      if (mem_ren) ren_cnt++;
    end
    check("bp_ren_cnt", 32'(ren_cnt), 32'd2);
    check("bp_level", 32'(rd_level), 32'd6);
    check("bp_valid", 32'(rd_valid), 32'd1);
    check("bp_hold", 32'(rd_data), 32'(mem[0]));
    for (int i = 0; i < 8; i++) exp_q.push_back(mem[i]);
    rd_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      watch("bp_pop");
      cyc(); #1;
    end
    check("bp_left", 32'(exp_q.size()), 32'd0);
    check("bp_valid_end", 32'(rd_valid), 32'd0);
    check("bp_level_end", 32'(rd_level), 32'd0);

    // walk the pointers to 31, then wrap through 0
    do_reset();
    rd_ready = 1'b1;
    for (int b = 1; b <= 31; b++) begin
      cyc();
      wptr_gray_sync = gray(5'(b));
      exp_q.push_back(mem[(b - 1) & 15]);
      #1;
      watch("walk_pop");
    end
    repeat (6) begin
      cyc(); #1;
      watch("walk_pop");
    end
    check("walk_left", 32'(exp_q.size()), 32'd0);
    check("walk_rptr", 32'(rptr_gray), 32'h10);
    cyc();
    wptr_gray_sync = 5'h00;
    exp_q.push_back(mem[15]);
    #1;
    check("wrap_ren_a", 32'(mem_ren), 32'd1);
    check("wrap_raddr_a", 32'(mem_raddr), 32'd15);
    check("wrap_rptr_a", 32'(rptr_gray), 32'h10);
    watch("wrap_pop");
    cyc();
    wptr_gray_sync = 5'h01;
    exp_q.push_back(mem[0]);
    #1;
    check("wrap_ren_b", 32'(mem_ren), 32'd1);
    check("wrap_raddr_b", 32'(mem_raddr), 32'd0);
    check("wrap_rptr_b", 32'(rptr_gray), 32'h00);
    watch("wrap_pop");
    cyc(); #1;
    check("wrap_rptr_c", 32'(rptr_gray), 32'h01);
    check("wrap_ren_c", 32'(mem_ren), 32'd0);
    watch("wrap_pop");
    cyc(); #1;
    watch("wrap_pop");
    cyc(); #1;
    check("wrap_left", 32'(exp_q.size()), 32'd0);

    // illegal pointer hop, then reset while a word is buffered and one is in flight
    do_reset();
    cyc(); #1;
    check("err_idle", 32'(err), 32'd0);
    cyc();
    wptr_gray_sync = 5'h03;
    #1;
    check("err_same_cycle", 32'(err), 32'd0);
    cyc(); #1;
    check("err_next", 32'(err), 32'(ERR_EXP));
    cyc(); #1;
    check("err_sticky", 32'(err), 32'(ERR_EXP));
    check("mr_valid_pre", 32'(rd_valid), 32'd1);
    check("mr_data_pre", 32'(rd_data), 32'(mem[0]));
    rst_n = 1'b0;
    #1;
    check("mr_valid", 32'(rd_valid), 32'd0);
    check("mr_empty", 32'(empty), 32'd1);
    check("mr_data", 32'(rd_data), 32'd0);
    check("mr_rptr", 32'(rptr_gray), 32'd0);
    check("mr_ren", 32'(mem_ren), 32'd0);
    check("mr_err", 32'(err), 32'd0);
    wptr_gray_sync = 5'h00;
    cyc();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc(); #1;
      check($sformatf("mr_no_stale_c%0d", c), 32'(rd_valid), 32'd0);
    end
    cyc();
    wptr_gray_sync = 5'h01;
    #1;
    check("mr_ren_new", 32'(mem_ren), 32'd1);
    cyc(); cyc(); #1;
    check("mr_valid_new", 32'(rd_valid), 32'd1);
    check("mr_data_new", 32'(rd_data), 32'(mem[0]));
    check("mr_err_end", 32'(err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
